leaf_kernel_ctrl: RTL and testbench

LEAF_KERNEL_CTRL -- requirements
Module: leaf_kernel_ctrl

---
 rtl/leaf_kernel_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_leaf_kernel_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_kernel_ctrl.sv
// leaf_kernel_ctrl
// Per-kernel start/reset/done sequencer between a host and user kernels.
// Each channel synchronises its ap_start bit and detects rising edges. On a
// start event it issues a fixed-width kernel_reset pulse and then enables the
// kernel until it reports done. An optional RUN-state timeout parks the
// channel in an error state with a sticky flag.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high
//   ap_start       : [NUM_KERNELS] host start requests (rising edge = start)
//   ap_done_user   : [NUM_KERNELS] kernel completion, only looked at in RUN
//   ap_start_user  : [NUM_KERNELS] kernel enable, high in RUN
//   kernel_reset   : [NUM_KERNELS] per-kernel reset pulse, high in RST
//   ap_done        : [NUM_KERNELS] high in DONE
//   timeout        : [NUM_KERNELS] sticky timeout flag
//   all_idle       : registered AND of every channel's IDLE flag
module leaf_kernel_ctrl #(
  parameter int          NUM_KERNELS        = 1,
  parameter int          SYNC_STAGES        = 2,
  parameter int          RESET_PULSE_CYCLES = 4,
  parameter logic [31:0] TIMEOUT_CYCLES     = 32'd0,
  parameter bit          RESTART_EN         = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_KERNELS-1:0] ap_start,
  input  logic [NUM_KERNELS-1:0] ap_done_user,
  output logic [NUM_KERNELS-1:0] ap_start_user,
  output logic [NUM_KERNELS-1:0] kernel_reset,
  output logic [NUM_KERNELS-1:0] ap_done,
  output logic [NUM_KERNELS-1:0] timeout,
  output logic                   all_idle
);

  localparam int                PCNT_W     = $clog2(RESET_PULSE_CYCLES + 1);
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(RESET_PULSE_CYCLES);
  // Last counter value of a RUN that is about to time out.
  localparam logic [31:0]       RUN_LAST   = TIMEOUT_CYCLES - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  logic [NUM_KERNELS-1:0] w_idle;
  logic                   r_all_idle;

  genvar g;
  generate
    for (g = 0; g < NUM_KERNELS; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_sync_prev;
      logic                   r_start_evt;
      state_t                 r_state;
      state_t                 w_state_nx;
      logic [PCNT_W-1:0]      r_pulse_cnt;
      logic [PCNT_W-1:0]      w_pulse_cnt_nx;
      logic [31:0]            r_run_cnt;
      logic [31:0]            w_run_cnt_nx;
      logic                   r_tmo;
      logic                   w_tmo_nx;
      logic                   r_start_user;
      logic                   r_kreset;
      logic                   r_done;
      logic                   w_sync_last;

      assign w_sync_last = r_sync[SYNC_STAGES-1];

      // Synchroniser and registered rising-edge detect. Clearing the chain in
      // reset makes a request held across reset release look like a fresh edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync      <= '0;
          r_sync_prev <= 1'b0;
          r_start_evt <= 1'b0;
        end else begin
          r_sync[0] <= ap_start[g];
          for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
          end
          r_sync_prev <= w_sync_last;
          r_start_evt <= w_sync_last & ~r_sync_prev;
        end
      end

      always_comb begin
        w_state_nx     = r_state;
        w_pulse_cnt_nx = r_pulse_cnt;
        w_run_cnt_nx   = r_run_cnt;
        w_tmo_nx       = r_tmo;
        case (r_state)
          S_IDLE: begin
            if (r_start_evt) begin
              w_state_nx     = S_RST;
              w_pulse_cnt_nx = PCNT_W'(1);
              w_tmo_nx       = 1'b0;
            end
          end
          S_RST: begin
            // r_pulse_cnt counts the RST cycles already spent, starting at 1.
            if (r_pulse_cnt == PULSE_LAST) begin
              w_state_nx   = S_RUN;
              w_run_cnt_nx = '0;
            end else begin
              w_pulse_cnt_nx = r_pulse_cnt + PCNT_W'(1);
            end
          end
          S_RUN: begin
            if (RESTART_EN && r_start_evt) begin
              w_state_nx     = S_RST;
              w_pulse_cnt_nx = PCNT_W'(1);
              w_run_cnt_nx   = '0;
              w_tmo_nx       = 1'b0;
            end else if (ap_done_user[g]) begin
              // Completion beats a timeout landing on the same cycle.
              w_state_nx = S_DONE;
            end else if ((TIMEOUT_CYCLES != 32'd0) && (r_run_cnt == RUN_LAST)) begin
              w_state_nx = S_ERR;
              w_tmo_nx   = 1'b1;
            end else if (r_run_cnt != '1) begin
              // Saturate rather than wrap when the timeout is disabled.
              w_run_cnt_nx = r_run_cnt + 32'd1;
            end
          end
          S_DONE, S_ERR: begin
            if (!w_sync_last) begin
              w_state_nx = S_IDLE;
            end
          end
          default: begin
            w_state_nx = S_IDLE;
          end
        endcase
      end

      // Outputs are decoded from the next state so they change on the same
      // edge as the state register.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state      <= S_IDLE;
          r_pulse_cnt  <= '0;
          r_run_cnt    <= '0;
          r_tmo        <= 1'b0;
          r_start_user <= 1'b0;
          r_kreset     <= 1'b0;
          r_done       <= 1'b0;
        end else begin
          r_state      <= w_state_nx;
          r_pulse_cnt  <= w_pulse_cnt_nx;
          r_run_cnt    <= w_run_cnt_nx;
          r_tmo        <= w_tmo_nx;
          r_start_user <= (w_state_nx == S_RUN);
          r_kreset     <= (w_state_nx == S_RST);
          r_done       <= (w_state_nx == S_DONE);
        end
      end

      assign ap_start_user[g] = r_start_user;
      assign kernel_reset[g]  = r_kreset;
      assign ap_done[g]       = r_done;
      assign timeout[g]       = r_tmo;
      assign w_idle[g]        = (r_state == S_IDLE);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_all_idle <= 1'b1;
    end else begin
      r_all_idle <= &w_idle;
    end
  end

  assign all_idle = r_all_idle;

endmodule

// File: tb/tb_leaf_kernel_ctrl.sv
// Bench for leaf_kernel_ctrl. Three instances with different parameter sets
// share clock and reset. A behavioural model (sample history plus per-channel
// phase with countdowns) predicts every output after each edge; predictions
// are queued and a negedge monitor compares them. A second queue holds
// hand-derived expectations for specific edges of the directed scenarios.
module tb_leaf_kernel_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [0:0] a_st, a_du, a_su, a_kr, a_dn, a_to;
  logic       a_ai;
  logic [3:0] b_st, b_du, b_su, b_kr, b_dn, b_to;
  logic       b_ai;
  logic [1:0] c_st, c_du, c_su, c_kr, c_dn, c_to;
  logic       c_ai;

  leaf_kernel_ctrl #(.NUM_KERNELS(1), .SYNC_STAGES(2), .RESET_PULSE_CYCLES(4),
                     .TIMEOUT_CYCLES(32'd8), .RESTART_EN(1'b0)) u_a (
    .clk(clk), .reset(rst), .ap_start(a_st), .ap_done_user(a_du),
    .ap_start_user(a_su), .kernel_reset(a_kr), .ap_done(a_dn),
    .timeout(a_to), .all_idle(a_ai));

  leaf_kernel_ctrl #(.NUM_KERNELS(4), .SYNC_STAGES(2), .RESET_PULSE_CYCLES(4),
                     .TIMEOUT_CYCLES(32'd0), .RESTART_EN(1'b1)) u_b (
    .clk(clk), .reset(rst), .ap_start(b_st), .ap_done_user(b_du),
    .ap_start_user(b_su), .kernel_reset(b_kr), .ap_done(b_dn),
    .timeout(b_to), .all_idle(b_ai));

  leaf_kernel_ctrl #(.NUM_KERNELS(2), .SYNC_STAGES(1), .RESET_PULSE_CYCLES(1),
                     .TIMEOUT_CYCLES(32'd3), .RESTART_EN(1'b1)) u_c (
    .clk(clk), .reset(rst), .ap_start(c_st), .ap_done_user(c_du),
    .ap_start_user(c_su), .kernel_reset(c_kr), .ap_done(c_dn),
    .timeout(c_to), .all_idle(c_ai));

  localparam int NKP  [3] = '{1, 4, 2};
  localparam int SSP  [3] = '{2, 2, 1};
  localparam int RPCP [3] = '{4, 4, 1};
  localparam int TOP  [3] = '{8, 0, 3};
  localparam int RSP  [3] = '{0, 1, 1};

  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_DONE = 3, P_ERR = 4;

  // Packed view of one instance: {all_idle, su[3:0], kr[3:0], dn[3:0], to[3:0]}
  localparam logic [16:0] AI  = 17'h10000;
  localparam logic [16:0] SU0 = 17'h01000;
  localparam logic [16:0] KR0 = 17'h00100;
  localparam logic [16:0] DN0 = 17'h00010;
  localparam logic [16:0] TO0 = 17'h00001;
  localparam logic [16:0] ALL = 17'h1FFFF;

  typedef struct { int d; int e; logic [16:0] exp; } sb_t;
  typedef struct { int d; int e; logic [16:0] m; logic [16:0] v; } gd_t;

  sb_t sb_q[$];
  gd_t gq[$];

  int  edge_n = 0;
  int  checks = 0;
  int  passes = 0;
  bit  closing = 1'b0;

  // Reference model state.
  int  ph   [3][4];
  int  left [3][4];
  int  ran  [3][4];
  bit  tmo  [3][4];
  bit  hs   [3][4][8];   // hs[..][0] = ap_start sample taken at the latest edge
  int  hn   [3][4];
  bit  m_ai [3];

  function automatic logic [3:0] st_of(input int d);
    case (d)
      0:       return {3'b000, a_st};
      1:       return b_st;
      default: return {2'b00, c_st};
    endcase
  endfunction

  function automatic logic [3:0] du_of(input int d);
    case (d)
      0:       return {3'b000, a_du};
      1:       return b_du;
      default: return {2'b00, c_du};
    endcase
  endfunction

  function automatic logic [16:0] act(input int d);
    case (d)
      0:       return {a_ai, 3'b0, a_su, 3'b0, a_kr, 3'b0, a_dn, 3'b0, a_to};
      1:       return {b_ai, b_su, b_kr, b_dn, b_to};
      default: return {c_ai, 2'b0, c_su, 2'b0, c_kr, 2'b0, c_dn, 2'b0, c_to};
    endcase
  endfunction

  // Sample taken 'b' edges before the latest one; nothing before reset.
  function automatic bit hg(input int d, input int c, input int b);
    if (b < hn[d][c]) return hs[d][c][b];
    return 1'b0;
  endfunction

  task automatic step_model();
    logic [3:0]  st;
    logic [3:0]  du;
    logic [16:0] e;
    bit          all_i;
    bit          sl;
    bit          ev;
    sb_t         it;
    for (int d = 0; d < 3; d++) begin
      st = st_of(d);
      du = du_of(d);
      e  = '0;
      if (rst) begin
        for (int c = 0; c < 4; c++) begin
          ph[d][c] = P_IDLE; left[d][c] = 0; ran[d][c] = 0;
          tmo[d][c] = 1'b0;  hn[d][c] = 0;
        end
        m_ai[d] = 1'b1;
      end else begin
        all_i = 1'b1;
        for (int c = 0; c < NKP[d]; c++) if (ph[d][c] != P_IDLE) all_i = 1'b0;
        m_ai[d] = all_i;
        for (int c = 0; c < NKP[d]; c++) begin
          // Synchronised level and start event as they stood before this edge.
          sl = hg(d, c, SSP[d] - 1);
          ev = hg(d, c, SSP[d]) & ~hg(d, c, SSP[d] + 1);
          case (ph[d][c])
            P_IDLE: if (ev) begin
              ph[d][c] = P_RST; left[d][c] = RPCP[d] - 1; tmo[d][c] = 1'b0;
            end
            P_RST: if (left[d][c] == 0) begin
              ph[d][c] = P_RUN; ran[d][c] = 1;
            end else left[d][c]--;
            P_RUN: if (RSP[d] == 1 && ev) begin
              ph[d][c] = P_RST; left[d][c] = RPCP[d] - 1; tmo[d][c] = 1'b0;
            end else if (du[c]) ph[d][c] = P_DONE;
            else if (TOP[d] != 0 && ran[d][c] == TOP[d]) begin
              ph[d][c] = P_ERR; tmo[d][c] = 1'b1;
            end else ran[d][c]++;
            default: if (!sl) ph[d][c] = P_IDLE;
          endcase
          for (int b = 7; b > 0; b--) hs[d][c][b] = hs[d][c][b-1];
          hs[d][c][0] = st[c];
          if (hn[d][c] < 8) hn[d][c]++;
        end
      end
      e[16] = m_ai[d];
      for (int c = 0; c < NKP[d]; c++) begin
        e[12+c] = (ph[d][c] == P_RUN);
        e[8+c]  = (ph[d][c] == P_RST);
        e[4+c]  = (ph[d][c] == P_DONE);
        e[c]    = tmo[d][c];
      end
      it.d = d; it.e = edge_n; it.exp = e;
      sb_q.push_back(it);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    step_model();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic gold(input int d, input int e, input logic [16:0] m, input logic [16:0] v);
    gd_t g;
    g.d = d; g.e = e; g.m = m; g.v = v;
    gq.push_back(g);
  endtask

  // Monitor: compare everything predicted for the edge just taken.
  always @(negedge clk) begin
    sb_t         it;
    logic [16:0] a;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      a  = act(it.d);
      checks++;
      if (a === it.exp) passes++;
      else $display("FAIL model dut%0d edge %0d: got %05h expected %05h", it.d, it.e, a, it.exp);
    end
    for (int i = gq.size() - 1; i >= 0; i--) begin
      if (gq[i].e == edge_n) begin
        a = act(gq[i].d);
        checks++;
        if ((a & gq[i].m) === gq[i].v) passes++;
        else $display("FAIL golden dut%0d edge %0d: got %05h expected %05h under mask %05h",
                      gq[i].d, gq[i].e, a & gq[i].m, gq[i].v, gq[i].m);
        gq.delete(i);
      end else if (closing && gq[i].e < edge_n) begin
        checks++;
        $display("FAIL golden dut%0d edge %0d: never compared, got none expected %05h",
                 gq[i].d, gq[i].e, gq[i].v);
        gq.delete(i);
      end
    end
  end

  initial begin
    int k;
    int r;
    rst = 1'b1;
    a_st = '0; a_du = '0; b_st = '0; b_du = '0; c_st = '0; c_du = '0;

    // Reset state
    gold(0, edge_n + 1, ALL, AI);
    gold(1, edge_n + 2, ALL, AI);
    gold(2, edge_n + 3, ALL, AI);
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // Basic start, pulse timing, done handshake
    a_st = 1'b1;
    k = edge_n + 1;
    gold(0, k + 2, KR0 | SU0, 17'h0);
    for (int j = 3; j <= 6; j++) gold(0, k + j, KR0 | SU0, KR0);
    gold(0, k + 7, KR0 | SU0, SU0);
    gold(0, k + 9, SU0 | DN0, SU0);
    ticks(10);
    a_du = 1'b1;
    gold(0, edge_n + 1, SU0 | DN0, DN0);
    tick();
    a_du = 1'b0; a_st = 1'b0;
    gold(0, edge_n + 1, SU0 | DN0, DN0);
    ticks(6);

    // Timeout: RUN lasts 8 cycles, flag sticks through IDLE
    a_st = 1'b1;
    k = edge_n + 1;
    gold(0, k + 14, SU0 | TO0, SU0);
    gold(0, k + 15, SU0 | TO0, TO0);
    ticks(17);
    a_st = 1'b0;
    ticks(5);
    gold(0, edge_n + 1, TO0 | AI, TO0 | AI);
    tick();

    // Next start clears the flag; a start event in RUN is ignored here
    a_st = 1'b1;
    k = edge_n + 1;
    gold(0, k + 2, TO0 | KR0, TO0);
    gold(0, k + 3, TO0 | KR0, KR0);
    ticks(9);
    a_st = 1'b0;
    tick();
    a_st = 1'b1;
    for (int j = 10; j <= 14; j++) gold(0, k + j, KR0 | SU0, SU0);
    ticks(6);
    a_st = 1'b0;
    ticks(5);

    // Done in the last RUN cycle wins over timeout
    a_st = 1'b1;
    k = edge_n + 1;
    ticks(15);
    a_du = 1'b1;
    gold(0, k + 15, SU0 | DN0 | TO0, DN0);
    tick();
    a_du = 1'b0; a_st = 1'b0;
    gold(0, edge_n + 1, DN0 | TO0, DN0);
    ticks(6);

    // Restart in RUN on the restart-enabled instance
    b_st = 4'b0001;
    ticks(9);
    b_st = 4'b0000;
    tick();
    b_st = 4'b0001;
    r = edge_n + 1;
    gold(1, r + 2, KR0 | SU0, SU0);
    for (int j = 3; j <= 6; j++) gold(1, r + j, KR0 | SU0, KR0);
    gold(1, r + 7, KR0 | SU0, SU0);
    ticks(9);
    b_du = 4'b0001;
    tick();
    b_du = 4'b0000; b_st = 4'b0000;
    ticks(6);

    // Channels 0 and 2 started two cycles apart
    b_st = 4'b0001;
    k = edge_n + 1;
    ticks(2);
    b_st = 4'b0101;
    gold(1, k + 3, KR0 | (KR0 << 2), KR0);
    gold(1, k + 5, KR0 | (KR0 << 2), KR0 | (KR0 << 2));
    gold(1, k + 7, SU0 | (KR0 << 2) | (SU0 << 2), SU0 | (KR0 << 2));
    gold(1, k + 9, SU0 | (SU0 << 2), SU0 | (SU0 << 2));
    ticks(10);
    b_du = 4'b0001;
    tick();
    b_du = 4'b0000; b_st = 4'b0100;
    ticks(6);
    gold(1, edge_n + 1, AI | SU0 | (SU0 << 2), SU0 << 2);
    tick();
    b_du = 4'b0100;
    tick();
    b_du = 4'b0000; b_st = 4'b0000;
    ticks(6);
    gold(1, edge_n + 1, AI, AI);
    tick();

    // Reset during RST with ap_start held high
    a_st = 1'b1;
    ticks(5);
    rst = 1'b1;
    gold(0, edge_n + 1, ALL, AI);
    tick();
    rst = 1'b0;
    r = edge_n + 1;
    gold(0, r + 2, KR0, 17'h0);
    gold(0, r + 3, KR0, KR0);
    gold(0, r + 15, TO0 | KR0, TO0);
    ticks(30);
    a_st = 1'b0;
    ticks(5);

    // Randomised traffic on all instances
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      a_st[0] = a_st[0] ^ ($urandom_range(0, 11) == 0);
      a_du[0] = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < 4; c++) begin
        b_st[c] = b_st[c] ^ ($urandom_range(0, 11) == 0);
        b_du[c] = ($urandom_range(0, 9) == 0);
      end
      for (int c = 0; c < 2; c++) begin
        c_st[c] = c_st[c] ^ ($urandom_range(0, 5) == 0);
        c_du[c] = ($urandom_range(0, 5) == 0);
      end
      tick();
    end
    rst = 1'b0;
    ticks(2);

    closing = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
